smart_bus_hv_bridge: RTL and testbench

Edge-of-array endpoint that closes the smart-bus loop between rows and columns. It captures a burst of words that a row of right-out smart MACs places on the horizontal smart bus. The words go into a local buffer and are later replayed, in order, onto the vertical smart bus feeding top-in smart MACs. It generates the select strobes both ends need, so the array controller only issues start pulses.

---
 rtl/smart_bus_hv_bridge_if.sv | 30 +++
 rtl/smart_bus_hv_bridge.sv | 150 +++++++++++++++
 tb/tb_smart_bus_hv_bridge.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/smart_bus_hv_bridge_if.sv
// Smart-bus bridge interface: the array controller's command lines and the row/column smart-bus
// signals that the bridge drives or samples.
interface smart_bus_hv_bridge_if #(
  parameter int WORD_SIZE = 16,
  parameter int LEN_W     = 4
);
  logic                 capture_start_in;
  logic [LEN_W-1:0]     capture_len_in;
  logic                 replay_start_in;
  logic [WORD_SIZE-1:0] horizontal_smart_bus_in;
  logic                 select_right_out_smart_out;
  logic [WORD_SIZE-1:0] vertical_smart_bus_out;
  logic                 select_top_in_smart_out;
  logic                 busy_out;
  logic                 done_out;
  logic [LEN_W-1:0]     count_out;
  logic                 err_out;

  modport slave (
    input  capture_start_in, capture_len_in, replay_start_in, horizontal_smart_bus_in,
    output select_right_out_smart_out, vertical_smart_bus_out, select_top_in_smart_out,
           busy_out, done_out, count_out, err_out
  );

  modport master (
    output capture_start_in, capture_len_in, replay_start_in, horizontal_smart_bus_in,
    input  select_right_out_smart_out, vertical_smart_bus_out, select_top_in_smart_out,
           busy_out, done_out, count_out, err_out
  );
endinterface

// File: rtl/smart_bus_hv_bridge.sv
// Edge-of-array bridge: captures a burst from the horizontal smart bus into a small buffer and
// replays it in order onto the vertical smart bus, generating both select strobes itself.
module smart_bus_hv_bridge #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 8,
  parameter int ADDR_W    = 3
) (
  input logic                  clk,
  input logic                  rst,
  smart_bus_hv_bridge_if.slave bus
);
  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, REPLAY} state_t;

  state_t               state, state_nxt;
  logic [LEN_W-1:0]     len_q, len_nxt;
  logic [LEN_W-1:0]     count_q, count_nxt;
  logic [LEN_W-1:0]     remaining_q, remaining_nxt;
  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_nxt;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_nxt;
  logic                 sel_right_q, sel_right_nxt;
  logic                 sel_top_q, sel_top_nxt;
  logic                 busy_q, busy_nxt;
  logic                 done_q, done_nxt;
  logic                 err_q, err_nxt;
  logic [WORD_SIZE-1:0] vert_q, vert_nxt;
  logic                 wr_en;
  logic                 len_ok;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign len_ok = (bus.capture_len_in != '0) && (bus.capture_len_in <= DEPTH_L);

  always_comb begin
    state_nxt     = state;
    len_nxt       = len_q;
    count_nxt     = count_q;
    remaining_nxt = remaining_q;
    wr_ptr_nxt    = wr_ptr_q;
    rd_ptr_nxt    = rd_ptr_q;
    sel_right_nxt = 1'b0;
    sel_top_nxt   = 1'b0;
    vert_nxt      = '0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    wr_en         = 1'b0;

    case (state)
      IDLE, HOLD: begin
        // Replay wins a tie so the buffered words are never clobbered; the dropped capture is flagged.
        if (bus.replay_start_in) begin
          if (count_q != '0) begin
            state_nxt     = REPLAY;
            vert_nxt      = mem[0];
            sel_top_nxt   = 1'b1;
            rd_ptr_nxt    = ADDR_W'(1);
            remaining_nxt = count_q - LEN_W'(1);
            err_nxt       = bus.capture_start_in;
          end else begin
            err_nxt = 1'b1;
          end
        end else if (bus.capture_start_in) begin
          if (len_ok) begin
            state_nxt     = CAPTURE;
            len_nxt       = bus.capture_len_in;
            wr_ptr_nxt    = '0;
            count_nxt     = '0;
            sel_right_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end

      CAPTURE: begin
        wr_en      = sel_right_q;
        wr_ptr_nxt = wr_ptr_q + ADDR_W'(1);
        count_nxt  = count_q + LEN_W'(1);
        if (count_nxt == len_q) begin
          state_nxt = HOLD;
          done_nxt  = 1'b1;
        end else begin
          sel_right_nxt = 1'b1;
        end
      end

      REPLAY: begin
        // The first word left on the start command, so remaining counts only the words still owed.
        if (remaining_q == '0) begin
          state_nxt = HOLD;
          done_nxt  = 1'b1;
        end else begin
          sel_top_nxt   = 1'b1;
          vert_nxt      = mem[rd_ptr_q];
          rd_ptr_nxt    = rd_ptr_q + ADDR_W'(1);
          remaining_nxt = remaining_q - LEN_W'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == CAPTURE) || (state_nxt == REPLAY);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      len_q       <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      sel_right_q <= 1'b0;
      sel_top_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      vert_q      <= '0;
    end else begin
      state       <= state_nxt;
      len_q       <= len_nxt;
      count_q     <= count_nxt;
      remaining_q <= remaining_nxt;
      wr_ptr_q    <= wr_ptr_nxt;
      rd_ptr_q    <= rd_ptr_nxt;
      sel_right_q <= sel_right_nxt;
      sel_top_q   <= sel_top_nxt;
      busy_q      <= busy_nxt;
      done_q      <= done_nxt;
      err_q       <= err_nxt;
      vert_q      <= vert_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= bus.horizontal_smart_bus_in;
    end
  end

  assign bus.select_right_out_smart_out = sel_right_q;
  assign bus.select_top_in_smart_out    = sel_top_q;
  assign bus.vertical_smart_bus_out     = vert_q;
  assign bus.busy_out                   = busy_q;
  assign bus.done_out                   = done_q;
  assign bus.count_out                  = count_q;
  assign bus.err_out                    = err_q;
endmodule

// File: tb/tb_smart_bus_hv_bridge.sv
// Bench for smart_bus_hv_bridge: command vector table, capture/replay sequences and a replay
// scoreboard that checks every word presented on the vertical bus.
module tb_smart_bus_hv_bridge;
  typedef struct {
    logic       cap;
    logic [3:0] len;
    logic       rep;
    logic       exp_err;
    logic       exp_busy;
    logic [3:0] exp_count;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        mon_en;
  int          checks;
  int          errors;
  logic [15:0] sb [$];
  logic [15:0] model_buf [8];
  int          model_count;
  logic [15:0] stim_vals [8];
  vec_t        vecs [5];

  smart_bus_hv_bridge_if #(.WORD_SIZE(16), .LEN_W(4)) bus ();

  smart_bus_hv_bridge #(.WORD_SIZE(16), .DEPTH(8), .ADDR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Holds the command for exactly one rising edge, returning at the negedge after it.
  task automatic applyStimulus(input logic cap, input logic [3:0] len, input logic rep);
    @(negedge clk);
    bus.capture_start_in = cap;
    bus.capture_len_in   = len;
    bus.replay_start_in  = rep;
    @(negedge clk);
    bus.capture_start_in = 1'b0;
    bus.capture_len_in   = '0;
    bus.replay_start_in  = 1'b0;
  endtask

  task automatic do_capture(input int len);
    applyStimulus(1'b1, 4'(len), 1'b0);
    checkOutput("capture_busy", bus.busy_out, 1);
    for (int i = 0; i < len; i++) begin
      checkOutput("select_right_high", bus.select_right_out_smart_out, 1);
      bus.horizontal_smart_bus_in = stim_vals[i];
      model_buf[i] = stim_vals[i];
      @(negedge clk);
    end
    bus.horizontal_smart_bus_in = '0;
    model_count = len;
    checkOutput("select_right_low", bus.select_right_out_smart_out, 0);
    checkOutput("capture_done", bus.done_out, 1);
    checkOutput("capture_count", bus.count_out, 32'(len));
    checkOutput("capture_idle_busy", bus.busy_out, 0);
    @(negedge clk);
    checkOutput("capture_done_pulse", bus.done_out, 0);
  endtask

  task automatic start_replay(input logic with_cap);
    for (int i = 0; i < model_count; i++) sb.push_back(model_buf[i]);
    applyStimulus(with_cap, 4'd2, 1'b1);
    checkOutput("replay_busy", bus.busy_out, 1);
    checkOutput("replay_err", bus.err_out, 32'(with_cap));
    checkOutput("replay_no_capture", bus.select_right_out_smart_out, 0);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.done_out) break;
      @(negedge clk);
    end
    checkOutput("replay_done", bus.done_out, 1);
    checkOutput("replay_select_off", bus.select_top_in_smart_out, 0);
    checkOutput("replay_count_kept", bus.count_out, 32'(model_count));
    checkOutput("scoreboard_drained", 32'(sb.size()), 0);
    @(negedge clk);
    checkOutput("replay_done_pulse", bus.done_out, 0);
  endtask

  // Scoreboard: every select_top cycle must carry the next expected word; otherwise the bus is 0.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.select_top_in_smart_out) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got 0x%0h, expected no word at %0t",
                   bus.vertical_smart_bus_out, $time);
        end else begin
          checkOutput("replay_word", bus.vertical_smart_bus_out, 32'(sb.pop_front()));
        end
      end else begin
        checkOutput("vert_idle_zero", bus.vertical_smart_bus_out, 0);
      end
      checkOutput("done_err_exclusive", 32'(bus.done_out & bus.err_out), 0);
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    model_count = 0;
    rst = 1'b0;
    bus.capture_start_in = 1'b0;
    bus.capture_len_in = '0;
    bus.replay_start_in = 1'b0;
    bus.horizontal_smart_bus_in = '0;

    vecs[0] = '{cap: 1'b1, len: 4'd0,  rep: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_count: 4'd0};
    vecs[1] = '{cap: 1'b1, len: 4'd9,  rep: 1'b0, exp_err: 1'b1, exp_busy: 1'b0, exp_count: 4'd0};
    vecs[2] = '{cap: 1'b0, len: 4'd0,  rep: 1'b1, exp_err: 1'b1, exp_busy: 1'b0, exp_count: 4'd0};
    vecs[3] = '{cap: 1'b1, len: 4'd15, rep: 1'b1, exp_err: 1'b1, exp_busy: 1'b0, exp_count: 4'd0};
    vecs[4] = '{cap: 1'b0, len: 4'd3,  rep: 1'b0, exp_err: 1'b0, exp_busy: 1'b0, exp_count: 4'd0};

    repeat (2) @(negedge clk);
    checkOutput("rst_select_right", bus.select_right_out_smart_out, 0);
    checkOutput("rst_select_top", bus.select_top_in_smart_out, 0);
    checkOutput("rst_vert", bus.vertical_smart_bus_out, 0);
    checkOutput("rst_busy", bus.busy_out, 0);
    checkOutput("rst_done", bus.done_out, 0);
    checkOutput("rst_count", bus.count_out, 0);
    checkOutput("rst_err", bus.err_out, 0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Illegal and empty-buffer commands from IDLE.
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].cap, vecs[v].len, vecs[v].rep);
      checkOutput("vec_err", bus.err_out, 32'(vecs[v].exp_err));
      checkOutput("vec_busy", bus.busy_out, 32'(vecs[v].exp_busy));
      checkOutput("vec_count", bus.count_out, 32'(vecs[v].exp_count));
      checkOutput("vec_no_select", bus.select_right_out_smart_out, 0);
      @(negedge clk);
      checkOutput("vec_err_pulse", bus.err_out, 0);
    end

    $display("[TB] capture 4 then replay");
    stim_vals[0] = 16'h0011; stim_vals[1] = 16'h0022;
    stim_vals[2] = 16'h0033; stim_vals[3] = 16'h0044;
    do_capture(4);
    start_replay(1'b0);
    wait_done(20);

    $display("[TB] full depth, replay twice");
    for (int i = 0; i < 8; i++) stim_vals[i] = 16'(i + 1);
    do_capture(8);
    start_replay(1'b0);
    wait_done(20);
    start_replay(1'b0);
    wait_done(20);

    $display("[TB] HOLD commands");
    stim_vals[0] = 16'hA1A1; stim_vals[1] = 16'hB2B2; stim_vals[2] = 16'hC3C3;
    do_capture(3);
    applyStimulus(1'b1, 4'd0, 1'b0);
    checkOutput("hold_bad_len_err", bus.err_out, 1);
    checkOutput("hold_bad_len_count", bus.count_out, 3);
    start_replay(1'b1);
    wait_done(20);

    // Capture request in the middle of a replay must be ignored without an error.
    start_replay(1'b0);
    bus.capture_start_in = 1'b1;
    bus.capture_len_in = 4'd2;
    @(negedge clk);
    bus.capture_start_in = 1'b0;
    bus.capture_len_in = '0;
    checkOutput("mid_replay_no_err", bus.err_out, 0);
    checkOutput("mid_replay_no_capture", bus.select_right_out_smart_out, 0);
    wait_done(20);

    $display("[TB] reset mid replay");
    for (int i = 0; i < 6; i++) stim_vals[i] = 16'(16'h0100 + i);
    do_capture(6);
    start_replay(1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sb.delete();
    checkOutput("abort_select_top", bus.select_top_in_smart_out, 0);
    checkOutput("abort_vert", bus.vertical_smart_bus_out, 0);
    checkOutput("abort_count", bus.count_out, 0);
    checkOutput("abort_no_done", bus.done_out, 0);
    checkOutput("abort_busy", bus.busy_out, 0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort_stays_quiet", bus.done_out | bus.select_top_in_smart_out, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
